// File: rtl/qsys_slave_responder.sv
// Avalon-MM slave traffic endpoint: tagged, rate-limited, in-order read responses.
// Optional random stall on waitrequest: define QSYS_SLAVE_RAND_STALL_EN.
module qsys_slave_responder #(
    parameter int WIDTH      = 32,
    parameter int ID         = 0,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_GAP   = 0,
    parameter int NUM_RESP   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  done,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic                  read,
    output logic [WIDTH-1:0]      readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest
);
    localparam int CW = WIDTH - 16;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PD = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [7:0] ID8 = 8'(ID);

    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fcnt, occ;
    logic [CW-1:0]    resp_count;
    logic [31:0]      wr_count, iss_count, gap_cnt;
    logic             full, stall, acc_rd, acc_wr;
    logic             in_v, fifo_empty, issue, push, pop;
    logic [WIDTH-1:0] req_word, in_d;

`ifdef QSYS_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1 ^ {8'h00, ID8};
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign full        = (occ == (AW+1)'(FIFO_DEPTH));
    assign waitrequest = rst | full | stall;
    assign acc_rd      = read & ~waitrequest;
    assign acc_wr      = write & ~waitrequest;
    assign req_word    = {ID8, writedata[WIDTH-1 -: 8], resp_count + CW'(1)};

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [PD-1:0]    pv;
            logic [WIDTH-1:0] pdat [PD];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= acc_rd;
                    for (int i = 1; i < PD; i++)
                        pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pdat[0] <= req_word;
                for (int i = 1; i < PD; i++)
                    pdat[i] <= pdat[i-1];
            end

            assign in_v = pv[PD-1];
            assign in_d = pdat[PD-1];
        end else begin : g_nopipe
            assign in_v = acc_rd;
            assign in_d = req_word;
        end
    endgenerate

    // An arriving word bypasses the FIFO when it is empty and the issue slot is open.
    assign fifo_empty = (fcnt == '0);
    assign issue      = (gap_cnt == 32'd0) & (~fifo_empty | in_v);
    assign pop        = issue & ~fifo_empty;
    assign push       = in_v & ~(issue & fifo_empty);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= in_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fcnt          <= '0;
            occ           <= '0;
            resp_count    <= '0;
            wr_count      <= '0;
            iss_count     <= '0;
            gap_cnt       <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fcnt <= fcnt + (AW+1)'(1);
            else if (!push && pop)
                fcnt <= fcnt - (AW+1)'(1);
            if (acc_rd && !issue)
                occ <= occ + (AW+1)'(1);
            else if (!acc_rd && issue)
                occ <= occ - (AW+1)'(1);
            if (acc_rd)
                resp_count <= resp_count + CW'(1);
            if (acc_wr)
                wr_count <= wr_count + 32'd1;
            readdatavalid <= issue;
            if (issue) begin
                readdata <= fifo_empty ? in_d : fifo_mem[rd_ptr];
                gap_cnt  <= 32'(RESP_GAP);
                if (iss_count != 32'hFFFF_FFFF)
                    iss_count <= iss_count + 32'd1;
            end else if (gap_cnt != 32'd0) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
        end
    end

    assign done = (iss_count >= 32'(NUM_RESP));

endmodule
